mem_arbiter: RTL and testbench

- Shares the single-ported `memory` block (req / addr_in / data_ready / data_out) between NUM_PORTS requesters, e.g. the eval FSM and a display/debug reader.
- Round-robin arbitration; one outstanding memory transaction at a time.
- Issues a one-cycle memory request pulse and returns the read word to the winning port.
- Sits between requester FSMs in `core` and the `memory` instance.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_arbiter_rr_pick.sv | 29 ++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-side types and default widths for core, memory and mem_arbiter.
package mem_pkg;

  localparam int DEF_NUM_PORTS      = 2;
  localparam int DEF_ADDR_W         = 12;
  localparam int DEF_DATA_W         = 16;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef logic [DEF_ADDR_W-1:0] address_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_t;

  // Width of a port index; never zero so single-bit vectors stay legal.
  function automatic int ptr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester after rr_ptr.
module rr_pick
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int PTR_W     = ptr_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic [NUM_PORTS-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = PTR_W'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-ported memory; one transaction in flight.
// Optional WAIT-state timeout enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_PORTS      = DEF_NUM_PORTS,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_err,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_ready,
  input  logic [DATA_W-1:0]           mem_data,
  output logic                        busy,
  output logic                        timeout_seen
);

  localparam int PTR_W = ptr_w(NUM_PORTS);

  arb_state_t             state;
  logic [PTR_W-1:0]       owner;
  logic [PTR_W-1:0]       rr_ptr;
  logic [NUM_PORTS-1:0]   gnt;
  logic [PTR_W-1:0]       gnt_idx;
  logic [ADDR_W-1:0]      gnt_addr;
  logic                   transfer;
  logic                   timed_out;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (gnt)
  );

  assign req_ready = (state == IDLE) ? gnt : '0;
  assign transfer  = |(req_valid & req_ready);
  assign busy      = (state != IDLE);

  always_comb begin
    gnt_idx  = '0;
    gnt_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PTR_W'(i);
        gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counter sits at zero outside WAIT, so it restarts on every WAIT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wait_cnt <= '0;
    else if (state != WAIT)  wait_cnt <= '0;
    else                     wait_cnt <= wait_cnt + 1'b1;
  end

  // A mem_ready arriving on the limit cycle takes precedence over the timeout.
  assign timed_out = (state == WAIT) && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timed_out          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= '0;
      rr_ptr       <= PTR_W'(NUM_PORTS - 1);
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      timeout_seen <= 1'b0;
    end else begin
      mem_req   <= 1'b0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            owner    <= gnt_idx;
            rr_ptr   <= gnt_idx;
            mem_addr <= gnt_addr;
            mem_req  <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            rsp_data         <= mem_data;
            rsp_valid[owner] <= 1'b1;
            state            <= RESP;
          end else if (timed_out) begin
            rsp_data         <= '0;
            rsp_err          <= 1'b1;
            timeout_seen     <= 1'b1;
            rsp_valid[owner] <= 1'b1;
            state            <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model with per-cycle compare plus directed literal checks.
module tb_mem_arbiter;

  localparam int NP = 2;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int TO = 8;
`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NP-1:0]    req_valid = '0;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP-1:0]    req_ready;
  logic [NP-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             rsp_err;
  logic             mem_req;
  logic [AW-1:0]    mem_addr;
  logic             mem_ready = 1'b0;
  logic [DW-1:0]    mem_data = '0;
  logic             busy;
  logic             timeout_seen;

  mem_arbiter #(
    .NUM_PORTS      (NP),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_data     (mem_data),
    .busy         (busy),
    .timeout_seen (timeout_seen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int lat = 2;
  bit stray = 1'b0;

  // Transaction-level model state
  bit            m_pend = 1'b0;
  bit            m_to = 1'b0;
  int            m_acc = 0;
  int            m_rsp_cyc = 0;
  int            m_owner = 0;
  int            m_last = NP - 1;
  int            n_acc = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  bit            m_tseen = 1'b0;

  // Observations of the DUT for directed checks
  int            g_log[$];
  int            v_log[$];
  logic [DW-1:0] d_log[$];
  int            acc_cyc_last = 0;
  int            rsp_cyc_last = 0;
  logic          err_last = 1'b0;

  function automatic logic [DW-1:0] content(logic [AW-1:0] a);
    case (a)
      12'h001: return 16'h002A;
      12'h010: return 16'h1234;
      12'h020: return 16'hABCD;
      default: return {4'hC, a};
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Memory responder follows the model's schedule, not the DUT's mem_req.
  always @(posedge clk) begin
    cyc++;
    #2;
    mem_ready = stray || (m_pend && (cyc == m_acc + 1 + lat));
    if (stray)          mem_data = 16'hBEEF;
    else if (mem_ready) mem_data = content(m_addr);
    else                mem_data = 16'h5A5A;
  end

  always @(negedge clk) begin
    logic [NP-1:0] e_rdy;
    logic [NP-1:0] e_rv;
    logic          e_mreq;
    logic          e_busy;
    logic          e_err;
    int            j;
    if (!rst_n) begin
      m_pend = 1'b0; m_last = NP - 1; m_addr = '0; m_data = '0; m_tseen = 1'b0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_timeout_seen", timeout_seen, 0);
    end else begin
      e_rdy = '0;
      if (!m_pend) begin
        for (int i = 1; i <= NP; i++) begin
          j = (m_last + i) % NP;
          if (req_valid[j] && e_rdy == '0) e_rdy[j] = 1'b1;
        end
      end
      e_mreq = m_pend && (cyc == m_acc + 1);
      e_busy = m_pend && (cyc > m_acc);
      e_rv   = '0;
      e_err  = 1'b0;
      if (m_pend && cyc == m_rsp_cyc) begin
        e_rv[m_owner] = 1'b1;
        m_data = m_to ? '0 : content(m_addr);
        e_err  = m_to;
        if (m_to) m_tseen = 1'b1;
      end
      chk("req_ready", req_ready, e_rdy);
      chk("mem_req", mem_req, e_mreq);
      chk("mem_addr", mem_addr, m_addr);
      chk("busy", busy, e_busy);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_err", rsp_err, e_err);
      chk("timeout_seen", timeout_seen, m_tseen);

      if (|(req_valid & req_ready)) begin
        for (int i = 0; i < NP; i++) if (req_ready[i]) g_log.push_back(i);
        acc_cyc_last = cyc;
      end
      if (|rsp_valid) begin
        v_log.push_back(int'(rsp_valid));
        d_log.push_back(rsp_data);
        rsp_cyc_last = cyc;
        err_last     = rsp_err;
      end

      if (m_pend && cyc == m_rsp_cyc) begin
        m_pend = 1'b0;
      end else if (!m_pend && |(req_valid & e_rdy)) begin
        for (int i = 0; i < NP; i++) if (e_rdy[i]) m_owner = i;
        m_pend    = 1'b1;
        m_acc     = cyc;
        m_addr    = req_addr[m_owner*AW +: AW];
        m_last    = m_owner;
        m_to      = TO_EN && (lat > TO);
        m_rsp_cyc = cyc + 2 + (m_to ? TO : lat);
        n_acc++;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(int target, string name);
    int k = 0;
    while (n_acc < target && k < 200) begin
      @(posedge clk); #1; k++;
    end
    n_cmp++;
    if (n_acc < target) begin
      n_fail++;
      $display("FAIL %s accept wait: got %0d accepts expected %0d", name, n_acc, target);
    end
  endtask

  task automatic wait_idle(string name);
    int k = 0;
    while (m_pend && k < 2000) begin
      @(posedge clk); #1; k++;
    end
    n_cmp++;
    if (m_pend) begin
      n_fail++;
      $display("FAIL %s idle wait: still pending after %0d cycles, expected idle", name, k);
    end
  endtask

  task automatic clear_logs();
    g_log.delete(); v_log.delete(); d_log.delete();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  function automatic int qv(int idx);
    return (idx < v_log.size()) ? v_log[idx] : -1;
  endfunction

  function automatic int qg(int idx);
    return (idx < g_log.size()) ? g_log[idx] : -1;
  endfunction

  function automatic logic [DW-1:0] qd(int idx);
    return (idx < d_log.size()) ? d_log[idx] : 16'hxxxx;
  endfunction

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Single request from port 0
    clear_logs();
    lat = 2;
    req_addr[0 +: AW] = 12'h001;
    req_valid = 2'b01;
    wait_acc(n_acc + 1, "t1");
    req_valid = '0;
    wait_idle("t1");
    tick(2);
    chk("t1_nrsp", v_log.size(), 1);
    chk("t1_rsp_valid", qv(0), 1);
    chk("t1_rsp_data", qd(0), 16'h002A);
    chk("t1_latency", rsp_cyc_last - acc_cyc_last, 4);

    // Both ports held: grants alternate starting with port 0
    reset_dut();
    clear_logs();
    lat = 1;
    req_addr[0 +: AW]  = 12'h010;
    req_addr[AW +: AW] = 12'h020;
    req_valid = 2'b11;
    wait_acc(n_acc + 4, "t2");
    req_valid = '0;
    wait_idle("t2");
    tick(2);
    chk("t2_grant0", qg(0), 0);
    chk("t2_grant1", qg(1), 1);
    chk("t2_grant2", qg(2), 0);
    chk("t2_grant3", qg(3), 1);
    chk("t2_data0", qd(0), 16'h1234);
    chk("t2_data1", qd(1), 16'hABCD);
    chk("t2_data2", qd(2), 16'h1234);
    chk("t2_data3", qd(3), 16'hABCD);
    chk("t2_valid1", qv(1), 2);

    // Reset during WAIT, then a late mem_ready
    clear_logs();
    lat = 6;
    req_addr[AW +: AW] = 12'h055;
    req_valid = 2'b10;
    wait_acc(n_acc + 1, "t3");
    req_valid = '0;
    tick(2);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    stray = 1'b1;
    tick(1);
    stray = 1'b0;
    tick(3);
    chk("t3_nrsp", v_log.size(), 0);
    chk("t3_busy", busy, 0);
    chk("t3_rsp_data", rsp_data, 16'h0000);
    lat = 3;
    req_addr[0 +: AW] = 12'h001;
    req_valid = 2'b01;
    wait_acc(n_acc + 1, "t3b");
    req_valid = '0;
    wait_idle("t3b");
    tick(2);
    chk("t3b_rsp_valid", qv(0), 1);
    chk("t3b_rsp_data", qd(0), 16'h002A);

    // Stray mem_ready while idle
    clear_logs();
    stray = 1'b1;
    tick(1);
    stray = 1'b0;
    tick(3);
    chk("t4_rsp_data", rsp_data, 16'h002A);
    chk("t4_nrsp", v_log.size(), 0);
    chk("t4_busy", busy, 0);

    // Zero-latency memory
    clear_logs();
    lat = 0;
    req_addr[AW +: AW] = 12'h020;
    req_valid = 2'b10;
    wait_acc(n_acc + 1, "t5");
    req_valid = '0;
    wait_idle("t5");
    tick(2);
    chk("t5_latency", rsp_cyc_last - acc_cyc_last, 2);
    chk("t5_rsp_valid", qv(0), 2);
    chk("t5_rsp_data", qd(0), 16'hABCD);

`ifdef MEM_ARBITER_TIMEOUT_EN
    // Memory never ready: timeout response
    clear_logs();
    lat = 1000;
    req_addr[0 +: AW] = 12'h010;
    req_valid = 2'b01;
    wait_acc(n_acc + 1, "t6");
    req_valid = '0;
    wait_idle("t6");
    tick(3);
    chk("t6_latency", rsp_cyc_last - acc_cyc_last, 10);
    chk("t6_rsp_err", err_last, 1);
    chk("t6_rsp_data", qd(0), 16'h0000);
    chk("t6_timeout_seen", timeout_seen, 1);
    clear_logs();
    lat = 2;
    req_addr[AW +: AW] = 12'h020;
    req_valid = 2'b10;
    wait_acc(n_acc + 1, "t6b");
    req_valid = '0;
    wait_idle("t6b");
    tick(2);
    chk("t6b_rsp_err", err_last, 0);
    chk("t6b_rsp_data", qd(0), 16'hABCD);
    chk("t6b_timeout_seen", timeout_seen, 1);
`else
    chk("no_to_timeout_seen", timeout_seen, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
